// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter / fetch sequencer with relative branches, HALT detection and retire counter
module fetch_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [7:0]      HALT_OP  = 8'h88,
  parameter int              CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [PC_W-1:0]  start_addr_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             branchb_i,
  input  logic [PC_W-1:0]  offset_i,
  input  logic [7:0]       instr_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [7:0]       instr_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] icount_o
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  icount_q, icount_d;
  // next state: launch from IDLE/HALTED, retire one instruction per unstalled RUN cycle
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    if (state_q != RUN) begin
      if (start_i) begin
        state_d  = RUN;
        pc_d     = start_addr_i;
        icount_d = '0;
      end
    end else if (!stall_i) begin
      icount_d = (&icount_q) ? icount_q : icount_q + 1'b1;
      if (instr_i == HALT_OP) state_d = HALTED;
      else pc_d = branch_i ? pc_q + offset_i : branchb_i ? pc_q - offset_i : pc_q + 1'b1;
    end
  end
  // state register with asynchronous abort to IDLE
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
    end
  end
  assign pc_o     = pc_q;
  assign valid_o  = state_q == RUN;
  assign busy_o   = state_q == RUN;
  assign done_o   = state_q == HALTED;
  assign icount_o = icount_q;
  assign instr_o  = valid_o ? instr_i : 8'h00;
endmodule
